uartrx: RTL and testbench

Serial receiver that deserializes asynchronous UART frames from the `rx` pin into bytes for the front-panel/console logic. It pairs with the team's UART transmitter: same `baud`/`clock_rate` parameters, same bit period, LSB-first 8-bit data with one start bit and stop bits at 1. A received byte is held in an output register with a valid/read handshake; overrun and framing errors are flagged.

---
 rtl/uartrx.sv | 141 ++++++++++++++
 tb/tb_uartrx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uartrx.sv
// UART receiver: 8N1 frames from rx, LSB first, mid-bit sampling.
// Byte held in rx_data with valid/read handshake, overrun and framing flags.
module uartrx #(
  parameter int baud       = 10_000_000,
  parameter int clock_rate = 50_000_000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int P  = clock_rate / baud + 1;
  localparam int H  = P / 2;
  localparam int CW = (P > 2) ? $clog2(P) : 1;

  localparam logic [CW-1:0] CNT_P = CW'(P - 1);
  localparam logic [CW-1:0] CNT_H = CW'(H - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, nxt;
  logic          s1, rs;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic [7:0]    data_n;
  logic          valid_n, ovr_n, ferr_n;
  logic          brk, brk_n;

  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1 <= 1'b1;
      rs <= 1'b1;
    end else begin
      s1 <= rx;
      rs <= s1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      sh           <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      brk          <= 1'b0;
    end else begin
      state        <= nxt;
      cnt          <= cnt_n;
      idx          <= idx_n;
      sh           <= sh_n;
      rx_data      <= data_n;
      rx_valid     <= valid_n;
      rx_overrun   <= ovr_n;
      rx_frame_err <= ferr_n;
      brk          <= brk_n;
    end
  end

  always_comb begin
    nxt     = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    data_n  = rx_data;
    valid_n = rx_valid;
    ovr_n   = rx_overrun;
    ferr_n  = 1'b0;
    brk_n   = brk;

    if (rx_read && rx_valid) begin
      valid_n = 1'b0;
      ovr_n   = 1'b0;
    end

    unique case (state)
      IDLE: begin
        // after a break the line must be seen high before a new start
        if (rs) begin
          brk_n = 1'b0;
        end else if (!brk) begin
          nxt   = START;
          cnt_n = CNT_H;
        end
      end
      START: begin
        cnt_n = cnt - 1'b1;
        if (cnt == '0) begin
          if (rs) begin
            nxt = IDLE;
          end else begin
            nxt   = DATA;
            cnt_n = CNT_P;
            idx_n = '0;
          end
        end
      end
      DATA: begin
        cnt_n = cnt - 1'b1;
        if (cnt == '0) begin
          sh_n  = {rs, sh[7:1]};
          cnt_n = CNT_P;
          if (idx == 3'd7) nxt = STOP;
          else             idx_n = idx + 3'd1;
        end
      end
      STOP: begin
        cnt_n = cnt - 1'b1;
        if (cnt == '0) begin
          nxt = IDLE;
          if (rs) begin
            data_n  = sh;
            valid_n = 1'b1;
            if (rx_valid && !rx_read) ovr_n = 1'b1;
          end else begin
            ferr_n = 1'b1;
            brk_n  = 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_uartrx.sv
// Directed bench for uartrx at default parameters (6 clocks per bit).
// Frames are driven bit-by-bit; outputs sampled 1ns after rising edges.
module tb_uartrx;

  localparam int P = 6;

  logic       clk = 1'b0;
  logic       nrst;
  logic       rx;
  logic       rx_read;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       rx_busy;

  int errors   = 0;
  int checks   = 0;
  int ferr_cnt = 0;
  int ferr_ref;

  uartrx dut (
    .clk          (clk),
    .nrst         (nrst),
    .rx           (rx),
    .rx_read      (rx_read),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_frame_err) ferr_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // 10 bit times: start, 8 data LSB first, stop; optional read at stop edge
  task automatic send_frame(input logic [7:0] b,
                            input logic stop,
                            input logic rd);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      for (int j = 0; j < P; j++) begin
        if (rd && i == 9 && j == P - 1) rx_read = 1'b1;
        @(posedge clk);
        #1;
        rx_read = 1'b0;
      end
    end
  endtask

  task automatic pulse_read();
    rx_read = 1'b1;
    @(posedge clk);
    #1;
    rx_read = 1'b0;
  endtask

  initial begin
    nrst    = 1'b0;
    rx      = 1'b1;
    rx_read = 1'b0;
    cyc(3);
    chk("rst_data",  rx_data,      32'h00);
    chk("rst_valid", rx_valid,     32'h0);
    chk("rst_ovr",   rx_overrun,   32'h0);
    chk("rst_ferr",  rx_frame_err, 32'h0);
    chk("rst_busy",  rx_busy,      32'h0);
    nrst = 1'b1;
    cyc(4);

    // single good frame
    ferr_ref = ferr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_data",  rx_data,    32'hA5);
    chk("a5_valid", rx_valid,   32'h1);
    chk("a5_ovr",   rx_overrun, 32'h0);
    chk("a5_busy",  rx_busy,    32'h0);
    cyc(P);
    chk("a5_noferr", ferr_cnt - ferr_ref, 32'd0);
    pulse_read();
    chk("a5_read_valid", rx_valid, 32'h0);

    // overrun
    send_frame(8'h3C, 1'b1, 1'b0);
    chk("3c_data",  rx_data,    32'h3C);
    chk("3c_valid", rx_valid,   32'h1);
    chk("3c_ovr",   rx_overrun, 32'h0);
    cyc(P);
    send_frame(8'h81, 1'b1, 1'b0);
    chk("81_data",  rx_data,    32'h81);
    chk("81_valid", rx_valid,   32'h1);
    chk("81_ovr",   rx_overrun, 32'h1);
    cyc(P);
    pulse_read();
    chk("ovr_read_valid", rx_valid,   32'h0);
    chk("ovr_read_ovr",   rx_overrun, 32'h0);
    pulse_read();
    chk("idle_read_valid", rx_valid, 32'h0);

    // framing error, line then held low (break)
    ferr_ref = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    chk("fe_pulse", rx_frame_err, 32'h1);
    chk("fe_data",  rx_data,      32'h81);
    chk("fe_valid", rx_valid,     32'h0);
    cyc(1);
    chk("fe_end", rx_frame_err, 32'h0);
    cyc(20);
    chk("brk_idle", rx_busy, 32'h0);
    chk("fe_once",  ferr_cnt - ferr_ref, 32'd1);
    rx = 1'b1;
    cyc(P);
    chk("brk_release_busy", rx_busy, 32'h0);

    // 2-clock glitch: false start
    ferr_ref = ferr_cnt;
    rx = 1'b0;
    cyc(2);
    rx = 1'b1;
    cyc(2);
    chk("gl_busy_hi", rx_busy, 32'h1);
    cyc(2);
    chk("gl_busy_lo", rx_busy,  32'h0);
    cyc(P);
    chk("gl_data",  rx_data,  32'h81);
    chk("gl_valid", rx_valid, 32'h0);
    chk("gl_noferr", ferr_cnt - ferr_ref, 32'd0);

    // back-to-back 0x00, 0xFF; read between, read at second stop
    send_frame(8'h00, 1'b1, 1'b0);
    chk("b0_data",  rx_data,  32'h00);
    chk("b0_valid", rx_valid, 32'h1);
    pulse_read();
    cyc(P - 1);
    send_frame(8'hFF, 1'b1, 1'b1);
    chk("bf_data",  rx_data,    32'hFF);
    chk("bf_valid", rx_valid,   32'h1);
    chk("bf_ovr",   rx_overrun, 32'h0);
    cyc(P);

    // reset during data bit 4
    rx = 1'b0;
    cyc(P);
    for (int k = 0; k < 4; k++) begin
      rx = k[0];
      cyc(P);
    end
    rx = 1'b0;
    cyc(3);
    chk("mid_busy", rx_busy, 32'h1);
    nrst = 1'b0;
    #1;
    chk("mr_data",  rx_data,      32'h00);
    chk("mr_valid", rx_valid,     32'h0);
    chk("mr_ovr",   rx_overrun,   32'h0);
    chk("mr_ferr",  rx_frame_err, 32'h0);
    chk("mr_busy",  rx_busy,      32'h0);
    rx = 1'b1;
    cyc(2);
    nrst = 1'b1;
    cyc(P);
    chk("mr_after_busy", rx_busy, 32'h0);
    send_frame(8'h12, 1'b1, 1'b0);
    chk("12_data",  rx_data,  32'h12);
    chk("12_valid", rx_valid, 32'h1);
    cyc(P);

    // overrun then a read coinciding with the next good stop
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("5a_data", rx_data,    32'h5A);
    chk("5a_ovr",  rx_overrun, 32'h1);
    cyc(P);
    send_frame(8'hC3, 1'b1, 1'b1);
    chk("c3_data",  rx_data,    32'hC3);
    chk("c3_valid", rx_valid,   32'h1);
    chk("c3_ovr",   rx_overrun, 32'h0);
    cyc(P);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
